// File: rtl/rect_compositor.sv
// Multi-rectangle RGB565 compositor for the LCD test path, shadow/active banks.
// Optional define RECT_BLINK_EN adds a 6-bit frame counter driving ctrl bit1 blink.
module rect_compositor #(
    parameter int          NUM_RECTS = 4,
    parameter int          COORD_W   = 16,
    parameter logic [15:0] BG_COLOR  = 16'h0000
) (
    input  logic               PixelClk,
    input  logic               nRST,
    input  logic [COORD_W-1:0] PixelCount,
    input  logic [COORD_W-1:0] LineCount,
    input  logic               DE_in,
    input  logic               frame_start,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_idx,
    input  logic [2:0]         cfg_field,
    input  logic [COORD_W-1:0] cfg_data,
    output logic               DE_out,
    output logic [4:0]         LCD_R,
    output logic [5:0]         LCD_G,
    output logic [4:0]         LCD_B
);

    logic [COORD_W-1:0] r_sh_x0  [NUM_RECTS];
    logic [COORD_W-1:0] r_sh_x1  [NUM_RECTS];
    logic [COORD_W-1:0] r_sh_y0  [NUM_RECTS];
    logic [COORD_W-1:0] r_sh_y1  [NUM_RECTS];
    logic [15:0]        r_sh_col [NUM_RECTS];
    logic [1:0]         r_sh_ctrl[NUM_RECTS];

    logic [COORD_W-1:0] r_ac_x0  [NUM_RECTS];
    logic [COORD_W-1:0] r_ac_x1  [NUM_RECTS];
    logic [COORD_W-1:0] r_ac_y0  [NUM_RECTS];
    logic [COORD_W-1:0] r_ac_y1  [NUM_RECTS];
    logic [15:0]        r_ac_col [NUM_RECTS];
    logic [1:0]         r_ac_ctrl[NUM_RECTS];

    logic [NUM_RECTS-1:0] w_sel;
    logic [NUM_RECTS-1:0] w_en;
    logic [NUM_RECTS-1:0] w_hit;
    logic [NUM_RECTS-1:0] r_hit;
    logic                 r_de1;
    logic [15:0]          w_cfg_col;
    logic [15:0]          w_col;

    assign w_cfg_col = 16'(cfg_data);

    // Out-of-range indices match no slot, so they are dropped silently.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_RECTS; i++) begin
            w_sel[i] = cfg_we && (cfg_idx == 4'(i));
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                r_sh_x0[i]   <= '0;
                r_sh_x1[i]   <= '0;
                r_sh_y0[i]   <= '0;
                r_sh_y1[i]   <= '0;
                r_sh_col[i]  <= '0;
                r_sh_ctrl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                if (w_sel[i]) begin
                    case (cfg_field)
                        3'd0:    r_sh_x0[i]   <= cfg_data;
                        3'd1:    r_sh_x1[i]   <= cfg_data;
                        3'd2:    r_sh_y0[i]   <= cfg_data;
                        3'd3:    r_sh_y1[i]   <= cfg_data;
                        3'd4:    r_sh_col[i]  <= w_cfg_col;
                        3'd5:    r_sh_ctrl[i] <= cfg_data[1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Copy samples pre-edge shadow, so a coincident write waits a frame.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                r_ac_x0[i]   <= '0;
                r_ac_x1[i]   <= '0;
                r_ac_y0[i]   <= '0;
                r_ac_y1[i]   <= '0;
                r_ac_col[i]  <= '0;
                r_ac_ctrl[i] <= '0;
            end
        end else if (frame_start) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                r_ac_x0[i]   <= r_sh_x0[i];
                r_ac_x1[i]   <= r_sh_x1[i];
                r_ac_y0[i]   <= r_sh_y0[i];
                r_ac_y1[i]   <= r_sh_y1[i];
                r_ac_col[i]  <= r_sh_col[i];
                r_ac_ctrl[i] <= r_sh_ctrl[i];
            end
        end
    end

`ifdef RECT_BLINK_EN
    logic [5:0] r_fcnt;

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_fcnt <= '0;
        end else if (frame_start) begin
            r_fcnt <= r_fcnt + 6'd1;
        end
    end

    always_comb begin
        w_en = '0;
        for (int i = 0; i < NUM_RECTS; i++) begin
            w_en[i] = r_ac_ctrl[i][0] & ~(r_ac_ctrl[i][1] & r_fcnt[5]);
        end
    end
`else
    logic w_unused_blink;

    always_comb begin
        w_en           = '0;
        w_unused_blink = 1'b0;
        for (int i = 0; i < NUM_RECTS; i++) begin
            w_en[i]        = r_ac_ctrl[i][0];
            w_unused_blink = w_unused_blink ^ r_ac_ctrl[i][1];
        end
    end
`endif

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_RECTS; i++) begin
            w_hit[i] = w_en[i]
                     && (PixelCount >= r_ac_x0[i])
                     && (PixelCount <  r_ac_x1[i])
                     && (LineCount  >= r_ac_y0[i])
                     && (LineCount  <  r_ac_y1[i]);
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_hit <= '0;
            r_de1 <= 1'b0;
        end else begin
            r_hit <= w_hit;
            r_de1 <= DE_in;
        end
    end

    // Walk from the highest index down so index 0 ends up winning.
    always_comb begin
        w_col = BG_COLOR;
        for (int i = NUM_RECTS - 1; i >= 0; i--) begin
            if (r_hit[i]) begin
                w_col = r_ac_col[i];
            end
        end
        if (!r_de1) begin
            w_col = 16'h0000;
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            DE_out <= 1'b0;
            LCD_R  <= '0;
            LCD_G  <= '0;
            LCD_B  <= '0;
        end else begin
            DE_out <= r_de1;
            LCD_R  <= w_col[15:11];
            LCD_G  <= w_col[10:5];
            LCD_B  <= w_col[4:0];
        end
    end

endmodule
